// File: rtl/fila_pkg.sv
// Shared types and helpers for the parametrised circular FIFO.
package fila_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } fila_state_t;

  // Circular pointer advance; depth need not be a power of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fila_mem.sv
// Storage array for fila_param: DEPTH x DATA_WIDTH registers, no reset.
// Ports: clk_i clock; we_i/waddr_i/wdata_i synchronous write;
//        raddr_i/rdata_o asynchronous read.
module fila_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fila_param.sv
// Parametrised synchronous circular FIFO with full/empty status and
// single-cycle overflow/underflow pulses.
// Ports: clock_10KHz, reset (sync, active-high), enqueue_in, dequeue_in,
//        data_in -> data_out (registered pop data), len_out, full_out,
//        empty_out, overflow_out, underflow_out.
// Optional: FILA_PEEK_EN adds peek_out (combinational head word, 0 when empty).
module fila_param
  import fila_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clock_10KHz,
  input  logic                  reset,
  input  logic                  enqueue_in,
  input  logic                  dequeue_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [LEN_WIDTH-1:0]  len_out,
  output logic                  full_out,
  output logic                  empty_out,
  output logic                  overflow_out,
  output logic                  underflow_out
`ifdef FILA_PEEK_EN
  ,
  output logic [DATA_WIDTH-1:0] peek_out
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  fila_state_t           state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push_ok, pop_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  fila_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk_i   (clock_10KHz),
    .we_i    (push_ok),
    .waddr_i (tail_q),
    .wdata_i (data_in),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  always_comb begin
    pop_ok  = dequeue_in && (state_q != S_EMPTY);
    // When full, a same-cycle pop frees head == tail; the async read
    // sees the old word before the write lands at the edge.
    push_ok = enqueue_in && ((state_q != S_FULL) || pop_ok);

    head_d = head_q;
    tail_d = tail_q;
    if (pop_ok)  head_d = PTR_W'(next_ptr(32'(head_q), DEPTH));
    if (push_ok) tail_d = PTR_W'(next_ptr(32'(tail_q), DEPTH));

    len_d  = len_q + LEN_WIDTH'(push_ok) - LEN_WIDTH'(pop_ok);
    data_d = pop_ok ? rd_data : data_q;
    ovf_d  = enqueue_in && !push_ok;
    unf_d  = dequeue_in && (state_q == S_EMPTY);

    if (len_d == '0)                         state_d = S_EMPTY;
    else if (len_d == LEN_WIDTH'(DEPTH))     state_d = S_FULL;
    else                                     state_d = S_PARTIAL;
  end

  always_ff @(posedge clock_10KHz) begin
    if (reset) begin
      state_q <= S_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign data_out      = data_q;
  assign len_out       = len_q;
  assign full_out      = (state_q == S_FULL);
  assign empty_out     = (state_q == S_EMPTY);
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

`ifdef FILA_PEEK_EN
  assign peek_out = (state_q == S_EMPTY) ? '0 : rd_data;
`endif

endmodule

// File: tb/tb_fila_param.sv
module tb_fila_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        e8, d8, f8, em8, ov8, un8;
  logic [7:0]  x8, do8;
  logic [3:0]  l8;
  logic        e16, d16, f16, em16, ov16, un16;
  logic [15:0] x16, do16;
  logic [2:0]  l16;
`ifdef FILA_PEEK_EN
  logic [7:0]  pk8;
  logic [15:0] pk16;
`endif

  fila_param u8 (
    .clock_10KHz (clk), .reset (rst), .enqueue_in (e8), .dequeue_in (d8),
    .data_in (x8), .data_out (do8), .len_out (l8), .full_out (f8),
    .empty_out (em8), .overflow_out (ov8), .underflow_out (un8)
`ifdef FILA_PEEK_EN
    , .peek_out (pk8)
`endif
  );

  fila_param #(.DATA_WIDTH(16), .DEPTH(5)) u16 (
    .clock_10KHz (clk), .reset (rst), .enqueue_in (e16), .dequeue_in (d16),
    .data_in (x16), .data_out (do16), .len_out (l16), .full_out (f16),
    .empty_out (em16), .overflow_out (ov16), .underflow_out (un16)
`ifdef FILA_PEEK_EN
    , .peek_out (pk16)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference: plain queues plus the expected registered outputs.
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic [7:0]  m_do8;
  logic [15:0] m_do16;
  bit          m_ov8, m_un8, m_ov16, m_un16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit pop, push;
    if (rst) begin
      q8.delete(); q16.delete();
      m_do8 = '0; m_do16 = '0;
      m_ov8 = 0; m_un8 = 0; m_ov16 = 0; m_un16 = 0;
    end else begin
      pop   = d8 && q8.size() > 0;
      push  = e8 && (q8.size() < 8 || pop);
      m_un8 = d8 && q8.size() == 0;
      m_ov8 = e8 && !push;
      if (pop)  m_do8 = q8.pop_front();
      if (push) q8.push_back(x8);
      pop    = d16 && q16.size() > 0;
      push   = e16 && (q16.size() < 5 || pop);
      m_un16 = d16 && q16.size() == 0;
      m_ov16 = e16 && !push;
      if (pop)  m_do16 = q16.pop_front();
      if (push) q16.push_back(x16);
    end
    @(posedge clk);
    #1;
    chk("dout8", do8, m_do8);
    chk("len8", l8, q8.size());
    chk("full8", f8, q8.size() == 8);
    chk("empty8", em8, q8.size() == 0);
    chk("ovf8", ov8, m_ov8);
    chk("unf8", un8, m_un8);
    chk("dout16", do16, m_do16);
    chk("len16", l16, q16.size());
    chk("full16", f16, q16.size() == 5);
    chk("empty16", em16, q16.size() == 0);
    chk("ovf16", ov16, m_ov16);
    chk("unf16", un16, m_un16);
`ifdef FILA_PEEK_EN
    chk("peek8", pk8, (q8.size() > 0) ? q8[0] : 8'h0);
    chk("peek16", pk16, (q16.size() > 0) ? q16[0] : 16'h0);
`endif
  endtask

  task automatic s8(input bit e, input bit d, input logic [7:0] x);
    e8 = e; d8 = d; x8 = x; e16 = 0; d16 = 0;
    tick();
  endtask

  task automatic s16(input bit e, input bit d, input logic [15:0] x);
    e16 = e; d16 = d; x16 = x; e8 = 0; d8 = 0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1; e8 = 1; d8 = 1; x8 = 8'h55; e16 = 1; d16 = 1; x16 = 16'h5555;
    tick();
    rst = 0;
  endtask

  initial begin
    int cnt;
    logic [7:0] first;
    rst = 0; e8 = 0; d8 = 0; x8 = '0; e16 = 0; d16 = 0; x16 = '0;

    do_reset();
    chk("rst_len8", l8, 0);
    chk("rst_empty8", em8, 1);
    chk("rst_dout16", do16, 0);

    // Fill with 0..10, one idle cycle after 3.
    cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      s8(1, 0, 8'(i));
      cnt += int'(ov8);
      if (i == 3) s8(0, 0, 8'hEE);
    end
    chk("fill_len8", l8, 8);
    chk("fill_full8", f8, 1);
    chk("ovf_pulses8", cnt, 3);

    // Drain with 11 pops.
    cnt = 0;
    for (int i = 0; i < 11; i++) begin
      s8(0, 1, 8'h00);
      if (i < 8) chk("drain_order8", do8, 8'(i));
      cnt += int'(un8);
    end
    chk("unf_pulses8", cnt, 3);
    chk("drain_hold8", do8, 7);
    chk("drain_empty8", em8, 1);

    // Wrap-around.
    for (int i = 0; i < 5; i++) s8(1, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 5; i++) s8(0, 1, 8'h00);
    for (int i = 0; i < 6; i++) s8(1, 0, 8'(8'hA0 + i));
    for (int i = 0; i < 6; i++) begin
      s8(0, 1, 8'h00);
      chk("wrap_order8", do8, 8'(8'hA0 + i));
    end

    // Simultaneous push+pop when full, then when empty.
    for (int i = 0; i < 8; i++) begin
      x8 = 8'($urandom_range(0, 254));
      if (i == 0) first = x8;
      s8(1, 0, x8);
    end
    s8(1, 1, 8'hFF);
    chk("simul_full_len", l8, 8);
    chk("simul_full_ovf", ov8, 0);
    chk("simul_full_dout", do8, first);
    for (int i = 0; i < 8; i++) s8(0, 1, 8'h00);
    chk("simul_full_last", do8, 8'hFF);
    s8(1, 1, 8'h3C);
    chk("simul_empty_len", l8, 1);
    chk("simul_empty_unf", un8, 1);
    s8(0, 1, 8'h00);

    // Reset mid-stream at len 5.
    for (int i = 0; i < 5; i++) s8(1, 0, 8'(8'h10 + i));
    chk("pre_rst_len", l8, 5);
    do_reset();
    chk("mid_rst_len", l8, 0);
    chk("mid_rst_dout", do8, 0);
    s8(0, 1, 8'h00);
    chk("mid_rst_unf", un8, 1);

    // Non-power-of-two instance: fill, drain, wrap.
    cnt = 0;
    for (int i = 0; i <= 10; i++) begin
      s16(1, 0, 16'(16'h1000 + i));
      cnt += int'(ov16);
      if (i == 3) s16(0, 0, 16'hEEEE);
    end
    chk("fill_len16", l16, 5);
    chk("ovf_pulses16", cnt, 6);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      s16(0, 1, 16'h0);
      if (i < 5) chk("drain_order16", do16, 16'(16'h1000 + i));
      cnt += int'(un16);
    end
    chk("unf_pulses16", cnt, 3);
    for (int i = 0; i < 3; i++) s16(1, 0, 16'(16'hA0 + i));
    for (int i = 0; i < 3; i++) s16(0, 1, 16'h0);
    for (int i = 0; i < 4; i++) s16(1, 0, 16'(16'hA0 + i));
    for (int i = 0; i < 4; i++) begin
      s16(0, 1, 16'h0);
      chk("wrap_order16", do16, 16'(16'hA0 + i));
    end

    // Random traffic on both instances against the queue model.
    for (int i = 0; i < 400; i++) begin
      e8  = 1'($urandom_range(0, 1));
      d8  = 1'($urandom_range(0, 1));
      x8  = 8'($urandom);
      e16 = 1'($urandom_range(0, 1));
      d16 = 1'($urandom_range(0, 1));
      x16 = 16'($urandom);
      if ($urandom_range(0, 99) == 0) rst = 1;
      tick();
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
